// File: rtl/cpu_pkg.sv
// Encodings shared by the ControlUnit, LoadBox and the store path, so that the
// size field and FSM states mean the same thing everywhere in the CPU.
package cpu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } store_size_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } store_state_t;

  // Illegal size 11 is reported as misaligned so the request aborts cleanly.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_WORD: mis = (off != 2'b00);
      SZ_HALF: mis = off[0];
      SZ_BYTE: mis = 1'b0;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Lane merge for sub-word stores: drops the new halfword/byte into the old
// little-endian word at the lane selected by the byte offset.
module store_merge
  import cpu_pkg::*;
(
  input  logic [31:0]  old_word,
  input  logic [31:0]  new_data,
  input  store_size_t  size,
  input  logic [1:0]   byte_off,
  output logic [31:0]  merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_WORD: merged = new_data;
      SZ_HALF: begin
        if (byte_off[1]) merged[31:16] = new_data[15:0];
        else             merged[15:0]  = new_data[15:0];
      end
      SZ_BYTE: begin
        case (byte_off)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store path to Memoria: word stores write straight through, halfword/byte
// stores read the containing word, merge the lane and write it back.
module store_unit
  import cpu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_datain,
  input  logic [31:0]       mem_dataout,
  output logic              mem_own
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LATENCY - 1);

  store_state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  store_size_t       size_q;
  logic              mis_q;
  logic [31:0]       merge_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       merged;
  logic              accept;
  logic [ADDR_W-1:0] addr_aligned;

  assign accept       = req_valid && (state == ST_IDLE);
  assign addr_aligned = {addr_q[ADDR_W-1:2], 2'b00};

  store_merge u_merge (
    .old_word (merge_q),
    .new_data (data_q),
    .size     (size_q),
    .byte_off (addr_q[1:0]),
    .merged   (merged)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= SZ_WORD;
      mis_q    <= 1'b0;
      merge_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= req_addr;
        data_q <= req_data;
        size_q <= store_size_t'(req_size);
        mis_q  <= is_misaligned(req_size, req_addr[1:0]);
      end
      if (state == ST_RD_ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_RD_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      // The old word is valid exactly when the wait counter has run out.
      if (state == ST_RD_WAIT && wait_cnt == '0) begin
        merge_q <= mem_dataout;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    mem_addr   = '0;
    mem_wr     = 1'b0;
    mem_datain = '0;
    mem_own    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) state_nxt = ST_RESP;
          else if (req_size == SZ_WORD)               state_nxt = ST_WRITE;
          else                                        state_nxt = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        mem_own   = 1'b1;
        mem_addr  = addr_aligned;
        state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        mem_own  = 1'b1;
        mem_addr = addr_aligned;
        if (wait_cnt == '0) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        mem_own    = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = addr_aligned;
        mem_datain = merged;
        state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        done       = 1'b1;
        misaligned = mis_q;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: two instances (read latency 1 and 3), each behind a
// small word memory, with a write scoreboard checked on every mem_wr pulse.
module tb_store_unit;

  logic        clk;
  logic        Reset;
  logic [1:0]  req_valid, req_ready, done, misaligned, mem_wr, mem_own;
  logic [31:0] req_addr   [2];
  logic [31:0] req_data   [2];
  logic [1:0]  req_size   [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_datain [2];
  logic [31:0] mem_dataout[2];

  logic [31:0] mem   [2][64];
  logic [31:0] rpipe [2][4];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  logic [63:0] wq0[$];
  logic [63:0] wq1[$];

  int    checks   = 0;
  int    failures = 0;
  string step     = "init";

  store_unit #(.READ_LATENCY(1), .ADDR_W(32)) u_dut0 (
    .Clk(clk), .Reset(Reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .req_size(req_size[0]), .done(done[0]),
    .misaligned(misaligned[0]), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
    .mem_datain(mem_datain[0]), .mem_dataout(mem_dataout[0]), .mem_own(mem_own[0])
  );

  store_unit #(.READ_LATENCY(3), .ADDR_W(32)) u_dut1 (
    .Clk(clk), .Reset(Reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .req_size(req_size[1]), .done(done[1]),
    .misaligned(misaligned[1]), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
    .mem_datain(mem_datain[1]), .mem_dataout(mem_dataout[1]), .mem_own(mem_own[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: synchronous write, read data delayed to match each instance's latency.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[0][pl_idx] <= pl_val;
      mem[1][pl_idx] <= pl_val;
    end
    for (int d = 0; d < 2; d++) begin
      if (mem_wr[d]) mem[d][mem_addr[d][7:2]] <= mem_datain[d];
      rpipe[d][0] <= mem[d][mem_addr[d][7:2]];
      for (int i = 1; i < 4; i++) rpipe[d][i] <= rpipe[d][i-1];
    end
  end
  assign mem_dataout[0] = rpipe[0][0];
  assign mem_dataout[1] = rpipe[1][2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  function automatic int rl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic ref_mis(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b11) || (sz == 2'b00 && off != 2'b00) || (sz == 2'b01 && off[0]);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m, v;
    logic [4:0]  sh;
    sh = {off, 3'b000};
    case (sz)
      2'b00:   begin m = 32'hFFFF_FFFF;       v = wd; end
      2'b01:   begin m = 32'h0000_FFFF << sh; v = (wd & 32'h0000_FFFF) << sh; end
      2'b10:   begin m = 32'h0000_00FF << sh; v = (wd & 32'h0000_00FF) << sh; end
      default: begin m = 32'h0;               v = 32'h0; end
    endcase
    return (old & ~m) | (v & m);
  endfunction

  // Every write must be expected, in order, with an aligned address.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wr[d]) begin
        logic [63:0] e;
        chk("wr_own", 64'(mem_own[d]), 64'd1);
        if (d == 0) begin
          chk("wr_expected0", 64'(wq0.size() != 0), 64'd1);
          if (wq0.size() != 0) begin
            e = wq0.pop_front();
            chk("wr_addr_data0", {mem_addr[d], mem_datain[d]}, e);
          end
        end else begin
          chk("wr_expected1", 64'(wq1.size() != 0), 64'd1);
          if (wq1.size() != 0) begin
            e = wq1.pop_front();
            chk("wr_addr_data1", {mem_addr[d], mem_datain[d]}, e);
          end
        end
      end
      if (mem_own[d]) chk("own_addr_aligned", 64'(mem_addr[d][1:0]), 64'd0);
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic do_store(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz);
    logic        mis, mis_o;
    logic [63:0] e;
    int exp_lat, exp_wr, lat, wrc, own, busy_rdy, n;
    mis     = ref_mis(sz, a[1:0]);
    exp_lat = mis ? 1 : (sz == 2'b00 ? 2 : 3 + rl(d));
    exp_wr  = mis ? 0 : exp_lat - 1;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before", 64'(req_ready[d]), 64'd1);
    if (!mis) begin
      e = {a & 32'hFFFF_FFFC, ref_merge(mem[d][a[7:2]], wd, sz, a[1:0])};
      if (d == 0) wq0.push_back(e);
      else        wq1.push_back(e);
    end
    req_addr[d]  = a;
    req_data[d]  = wd;
    req_size[d]  = sz;
    req_valid[d] = 1'b1;
    @(posedge clk);
    lat = 0; wrc = 0; own = 0; busy_rdy = 0; mis_o = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[d] = 1'b0;
      if (mem_wr[d]) wrc = k;
      if (mem_own[d]) own++;
      if (done[d]) begin
        lat   = k;
        mis_o = misaligned[d];
      end else if (req_ready[d]) begin
        busy_rdy++;
      end
    end
    chk("done_latency", 64'(lat), 64'(exp_lat));
    chk("misaligned", 64'(mis_o), 64'(mis));
    chk("wr_cycle", 64'(wrc), 64'(exp_wr));
    chk("own_cycles", 64'(own), 64'(exp_wr));
    chk("ready_while_busy", 64'(busy_rdy), 64'd0);
  endtask

  initial begin
    int lat;
    Reset     = 1'b1;
    req_valid = 2'b00;
    pl_en     = 1'b0;
    pl_idx    = '0;
    pl_val    = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0;
      req_data[d] = '0;
      req_size[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    step = "reset";
    for (int d = 0; d < 2; d++) begin
      chk("req_ready", 64'(req_ready[d]), 64'd1);
      chk("done", 64'(done[d]), 64'd0);
      chk("misaligned", 64'(misaligned[d]), 64'd0);
      chk("mem_wr", 64'(mem_wr[d]), 64'd0);
      chk("mem_own", 64'(mem_own[d]), 64'd0);
      chk("mem_addr", 64'(mem_addr[d]), 64'd0);
      chk("mem_datain", 64'(mem_datain[d]), 64'd0);
    end
    Reset = 1'b0;

    step = "sw";
    do_store(0, 32'h10, 32'hDEADBEEF, 2'b00);
    chk("mem_10", 64'(mem[0][4]), 64'hDEADBEEF);

    step = "sb_rl1";
    preload(6'd4, 32'h11223344);
    do_store(0, 32'h13, 32'h000000AA, 2'b10);
    chk("mem_10", 64'(mem[0][4]), 64'hAA223344);

    step = "sb_rl3";
    do_store(1, 32'h13, 32'h000000AA, 2'b10);
    chk("mem_10", 64'(mem[1][4]), 64'hAA223344);

    step = "sh_hi";
    preload(6'd8, 32'h11223344);
    do_store(0, 32'h22, 32'h0000BEEF, 2'b01);
    chk("mem_20", 64'(mem[0][8]), 64'hBEEF3344);
    step = "sh_lo";
    preload(6'd8, 32'h11223344);
    do_store(0, 32'h20, 32'h0000BEEF, 2'b01);
    chk("mem_20", 64'(mem[0][8]), 64'h1122BEEF);
    step = "sh_rl3";
    do_store(1, 32'h22, 32'h0000BEEF, 2'b01);
    chk("mem_20", 64'(mem[1][8]), 64'hBEEF3344);

    step = "misalign";
    do_store(0, 32'h06, 32'h12345678, 2'b00);
    do_store(0, 32'h01, 32'h12345678, 2'b01);
    do_store(0, 32'h10, 32'h12345678, 2'b11);
    do_store(1, 32'h03, 32'h12345678, 2'b00);
    chk("mem_10_kept", 64'(mem[0][4]), 64'hAA223344);

    step = "random";
    for (int i = 0; i < 12; i++) begin
      do_store(i % 2, 32'h60 + 32'($urandom_range(0, 31)), $urandom, 2'($urandom_range(0, 3)));
    end

    step = "reset_mid_rmw";
    preload(6'd16, 32'hCAFEF00D);
    @(negedge clk);
    req_addr[0]  = 32'h41;
    req_data[0]  = 32'h00000055;
    req_size[0]  = 2'b10;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("in_rd_wait_own", 64'(mem_own[0]), 64'd1);
    Reset = 1'b1;
    @(negedge clk);
    chk("req_ready", 64'(req_ready[0]), 64'd1);
    chk("mem_wr", 64'(mem_wr[0]), 64'd0);
    chk("mem_own", 64'(mem_own[0]), 64'd0);
    chk("done", 64'(done[0]), 64'd0);
    Reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("mem_40_kept", 64'(mem[0][16]), 64'hCAFEF00D);

    step = "back_to_back";
    preload(6'd12, 32'h55667788);
    preload(6'd13, 32'h00000000);
    wq0.push_back({32'h30, ref_merge(32'h55667788, 32'h99, 2'b10, 2'b01)});
    wq0.push_back({32'h34, 32'h12345678});
    @(negedge clk);
    chk("ready_before", 64'(req_ready[0]), 64'd1);
    req_addr[0]  = 32'h31;
    req_data[0]  = 32'h00000099;
    req_size[0]  = 2'b10;
    req_valid[0] = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_addr[0] = 32'h34;
        req_data[0] = 32'h12345678;
        req_size[0] = 2'b00;
      end
      if (done[0]) lat = k;
    end
    chk("sb_latency", 64'(lat), 64'd4);
    @(negedge clk);
    chk("ready_after_done", 64'(req_ready[0]), 64'd1);
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[0] = 1'b0;
      if (done[0]) lat = k;
    end
    chk("sw_latency", 64'(lat), 64'd2);
    chk("mem_30", 64'(mem[0][12]), 64'h55669988);
    chk("mem_34", 64'(mem[0][13]), 64'h12345678);

    repeat (4) @(negedge clk);
    step = "end";
    chk("queue0_empty", 64'(wq0.size()), 64'd0);
    chk("queue1_empty", 64'(wq1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
